// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Constants shared by the pipeline-register slice and its bench: the NOP
//   instruction used as the empty IF/ID contents, register index width,
//   default control-bundle width and bit positions inside that bundle.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          REG_IDX_W      = 5;
    localparam int          CTRL_W_DEFAULT = 12;
    localparam int          CTRL_REGWRITE  = 0;
    localparam int          CTRL_MEMWRITE  = 1;

endpackage

// File: rtl/pipe_reg.sv
// pipe_reg
//   Generic pipeline register with synchronous active-low reset, synchronous
//   clear and load enable. Reset and clear both load RST_VAL, so a cleared
//   stage looks exactly like a freshly reset one.
// Ports
//   clk  in   rising-edge clock
//   rst  in   synchronous active-low reset (highest priority)
//   en   in   load d when high
//   clr  in   load RST_VAL (beats en)
//   d    in   W-bit data
//   q    out  W-bit registered data
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= RST_VAL;
        end else if (clr) begin
            data_q <= RST_VAL;
        end else if (en) begin
            data_q <= d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
//   Pipeline registers on the consumer side of the hazard unit: the PC, the
//   IF/ID register and the ID/EX register, plus saturating stall/flush
//   counters and a sticky flag raised when stallF persists STALL_MAX cycles.
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   stallF, stallD, flushD, flushE  hazard-unit controls
//   PCNextF, instrF, PCPlus4F     fetch-stage inputs
//   PCF                           fetch PC
//   instrD, PCD, PCPlus4D, validD IF/ID contents
//   ctrlD, RD1D, RD2D, immExtD, Rs1D, Rs2D, RdD  decode-stage inputs
//   ctrlE ... RdE, validE         ID/EX contents
//   stallCount, flushCount        saturating event counters
//   stallTimeout                  sticky long-stall flag
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              CTRL_W    = CTRL_W_DEFAULT,
    parameter int              CNT_W     = 16,
    parameter int              STALL_MAX = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallF,
    input  logic                 stallD,
    input  logic                 flushD,
    input  logic                 flushE,
    input  logic [XLEN-1:0]      PCNextF,
    output logic [XLEN-1:0]      PCF,
    input  logic [31:0]          instrF,
    input  logic [XLEN-1:0]      PCPlus4F,
    output logic [31:0]          instrD,
    output logic [XLEN-1:0]      PCD,
    output logic [XLEN-1:0]      PCPlus4D,
    output logic                 validD,
    input  logic [CTRL_W-1:0]    ctrlD,
    input  logic [XLEN-1:0]      RD1D,
    input  logic [XLEN-1:0]      RD2D,
    input  logic [XLEN-1:0]      immExtD,
    input  logic [REG_IDX_W-1:0] Rs1D,
    input  logic [REG_IDX_W-1:0] Rs2D,
    input  logic [REG_IDX_W-1:0] RdD,
    output logic [CTRL_W-1:0]    ctrlE,
    output logic [XLEN-1:0]      RD1E,
    output logic [XLEN-1:0]      RD2E,
    output logic [XLEN-1:0]      immExtE,
    output logic [XLEN-1:0]      PCE,
    output logic [XLEN-1:0]      PCPlus4E,
    output logic [REG_IDX_W-1:0] Rs1E,
    output logic [REG_IDX_W-1:0] Rs2E,
    output logic [REG_IDX_W-1:0] RdE,
    output logic                 validE,
    output logic [CNT_W-1:0]     stallCount,
    output logic [CNT_W-1:0]     flushCount,
    output logic                 stallTimeout
);

    localparam int IFID_W = 32 + 2 * XLEN + 1;
    localparam int IDEX_W = CTRL_W + 5 * XLEN + 3 * REG_IDX_W + 1;
    localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};
    localparam int RUN_W = $clog2(STALL_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_MAX);

    logic [IFID_W-1:0] ifid_d, ifid_q;
    logic [IDEX_W-1:0] idex_d, idex_q;

    pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(~stallF), .clr(1'b0), .d(PCNextF), .q(PCF)
    );

    // A loaded IF/ID entry is always a real instruction; a flushed one reverts to NOP.
    assign ifid_d = {instrF, PCF, PCPlus4F, 1'b1};

    pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
        .clk(clk), .rst(rst), .en(~stallD), .clr(flushD), .d(ifid_d), .q(ifid_q)
    );

    assign {instrD, PCD, PCPlus4D, validD} = ifid_q;

    assign idex_d = {ctrlD, RD1D, RD2D, immExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, validD};

    pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
        .clk(clk), .rst(rst), .en(1'b1), .clr(flushE), .d(idex_d), .q(idex_q)
    );

    assign {ctrlE, RD1E, RD2E, immExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, validE} = idex_q;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] stall_run_q, stall_run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_run_d = '0;
        if (stallF && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flushD && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (stallF) begin
            stall_run_d = (stall_run_q == RUN_MAX) ? RUN_MAX : stall_run_q + RUN_W'(1);
        end
        // Sticky: once the run length reaches STALL_MAX only reset clears it.
        timeout_d = timeout_q | (stall_run_d == RUN_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            stall_run_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stallCount   = stall_cnt_q;
    assign flushCount   = flush_cnt_q;
    assign stallTimeout = timeout_q;

endmodule
